// File: rtl/depth_frame_streamer.sv
// Purpose: stream a W x H depth frame from a 1-cycle-latency SRAM onto a valid/ready port.
// Latency: first beat is valid 2 cycles after the FRAME_START pulse, then one beat per cycle.
// Backpressure: a 2-entry output buffer absorbs READY=0; reads stop while the buffer would overfill.
//
// Ports:
//   i_CLK, i_RST                   clock, synchronous active-high reset
//   i_START, i_WIDTH, i_HEIGHT     frame request and dimensions, accepted in IDLE only
//   o_BUSY, o_DONE                 not-idle flag, 1-cycle completion pulse
//   o_FRAME_START, o_FRAME_FINISH  1-cycle framing pulses
//   o_XDS_VALID, i_XDS_READY       beat handshake
//   o_DEPTH, o_XDS_LAST            beat payload and final-beat marker
//   o_SRAM_CEN, o_SRAM_A, i_SRAM_Q read-only SRAM port (CEN active-low)
module depth_frame_streamer #(
    parameter int p_depth_bit        = 8,
    parameter int p_dim_bit          = 10,
    parameter int p_depth_sram_a_bit = 16
) (
    input  logic                          i_CLK,
    input  logic                          i_RST,
    input  logic                          i_START,
    input  logic [p_dim_bit-1:0]          i_WIDTH,
    input  logic [p_dim_bit-1:0]          i_HEIGHT,
    output logic                          o_BUSY,
    output logic                          o_DONE,
    output logic                          o_FRAME_START,
    output logic                          o_FRAME_FINISH,
    output logic                          o_XDS_VALID,
    input  logic                          i_XDS_READY,
    output logic [p_depth_bit-1:0]        o_DEPTH,
    output logic                          o_XDS_LAST,
    output logic                          o_SRAM_CEN,
    output logic [p_depth_sram_a_bit-1:0] o_SRAM_A,
    input  logic [p_depth_bit-1:0]        i_SRAM_Q
);

    localparam int LP_N_BIT = 2 * p_dim_bit;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_STREAM = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                r_state;
    logic [LP_N_BIT-1:0]   r_total;
    logic [LP_N_BIT-1:0]   r_issued;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_frame_start;
    logic                  r_frame_finish;

    // Output buffer: two entries of {data, last}
    logic [p_depth_bit-1:0] r_mem_dat [2];
    logic                   r_mem_last [2];
    logic                   r_rd_ptr;
    logic                   r_wr_ptr;
    logic [1:0]             r_count;

    logic                   w_valid;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_head_last;
    logic [1:0]             w_occ_after;
    logic                   w_room;
    logic                   w_active;
    logic                   w_issue;
    logic                   w_issue_last;

    assign w_valid     = (r_count != 2'd0);
    assign w_pop       = w_valid & i_XDS_READY;
    assign w_push      = r_inflight;
    assign w_head_last = r_mem_last[r_rd_ptr];

    // Occupancy is counted after this cycle's pop so a read can be issued in
    // the same cycle the head drains; this keeps a READY=1 stream bubble-free
    // while still never holding more than two unconsumed entries.
    assign w_occ_after  = r_count - {1'b0, w_pop};
    assign w_room       = ({1'b0, w_occ_after} + {2'b00, r_inflight}) < 3'd2;
    assign w_active     = (r_state == S_START) || (r_state == S_STREAM);
    assign w_issue      = w_active && w_room && (r_issued < r_total);
    assign w_issue_last = (r_issued == (r_total - LP_N_BIT'(1)));

    assign o_SRAM_CEN     = ~w_issue;
    assign o_SRAM_A       = p_depth_sram_a_bit'(r_issued);
    assign o_XDS_VALID    = w_valid;
    assign o_DEPTH        = r_mem_dat[r_rd_ptr];
    assign o_XDS_LAST     = w_valid & w_head_last;
    assign o_BUSY         = r_busy;
    assign o_DONE         = r_done;
    assign o_FRAME_START  = r_frame_start;
    assign o_FRAME_FINISH = r_frame_finish;

    // Control FSM with registered framing outputs and read-issue bookkeeping
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_state         <= S_IDLE;
            r_total         <= '0;
            r_issued        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_frame_start   <= 1'b0;
            r_frame_finish  <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue & w_issue_last;
            r_frame_start   <= 1'b0;
            r_frame_finish  <= 1'b0;
            r_done          <= 1'b0;
            if (w_issue) begin
                r_issued <= r_issued + LP_N_BIT'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (i_START) begin
                        r_total       <= LP_N_BIT'(i_WIDTH) * LP_N_BIT'(i_HEIGHT);
                        r_issued      <= '0;
                        r_state       <= S_START;
                        r_busy        <= 1'b1;
                        r_frame_start <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_total == '0) begin
                        r_state        <= S_FINISH;
                        r_frame_finish <= 1'b1;
                        r_done         <= 1'b1;
                    end else begin
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    // Only the final beat carries the last flag, so its handshake ends the frame
                    if (w_pop && w_head_last) begin
                        r_state        <= S_FINISH;
                        r_frame_finish <= 1'b1;
                        r_done         <= 1'b1;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output buffer: SRAM data lands here the cycle after its read was issued
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            for (int i = 0; i < 2; i++) begin
                r_mem_dat[i]  <= '0;
                r_mem_last[i] <= 1'b0;
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem_dat[r_wr_ptr]  <= i_SRAM_Q;
                r_mem_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_depth_frame_streamer.sv
module tb_depth_frame_streamer;

    logic        i_CLK = 1'b0;
    logic        i_RST;
    logic        i_START;
    logic [9:0]  i_WIDTH;
    logic [9:0]  i_HEIGHT;
    logic        i_XDS_READY;
    logic [7:0]  i_SRAM_Q;
    logic        o_BUSY, o_DONE, o_FRAME_START, o_FRAME_FINISH;
    logic        o_XDS_VALID, o_XDS_LAST, o_SRAM_CEN;
    logic [7:0]  o_DEPTH;
    logic [15:0] o_SRAM_A;

    depth_frame_streamer #(
        .p_depth_bit(8), .p_dim_bit(10), .p_depth_sram_a_bit(16)
    ) dut (
        .i_CLK(i_CLK), .i_RST(i_RST), .i_START(i_START),
        .i_WIDTH(i_WIDTH), .i_HEIGHT(i_HEIGHT),
        .o_BUSY(o_BUSY), .o_DONE(o_DONE),
        .o_FRAME_START(o_FRAME_START), .o_FRAME_FINISH(o_FRAME_FINISH),
        .o_XDS_VALID(o_XDS_VALID), .i_XDS_READY(i_XDS_READY),
        .o_DEPTH(o_DEPTH), .o_XDS_LAST(o_XDS_LAST),
        .o_SRAM_CEN(o_SRAM_CEN), .o_SRAM_A(o_SRAM_A), .i_SRAM_Q(i_SRAM_Q)
    );

    always #5 i_CLK = ~i_CLK;

    // SRAM model: data appears one cycle after the CEN=0 cycle
    logic [7:0] sram [0:255];
    always @(posedge i_CLK) begin
        if (!o_SRAM_CEN) i_SRAM_Q <= sram[o_SRAM_A[7:0]];
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] got_dat[$];
    bit         got_last[$];
    int         got_cyc[$];
    int start_cyc, finish_cyc, start_cnt, finish_cnt, done_cnt, cen_cnt, valid_cnt;
    int hold_viol, ahead_viol;
    bit busy_after, timed_out;

    // Drive one frame request; returns at posedge+1 of the START cycle
    task automatic launch(input int w, input int h);
        i_START  = 1'b1;
        i_WIDTH  = 10'(w);
        i_HEIGHT = 10'(h);
        @(posedge i_CLK); #1;
        i_START  = 1'b0;
    endtask

    // Run cycles, recording beats and pulses. Cycle 0 is the cycle it is entered.
    // rdy_mode 0: READY=1, 1: random. spc: cycle to pulse a 2x2 i_START.
    // stop_beats>0: return after that many beats. Always returns at posedge+1.
    task automatic collect(input int rdy_mode, input int spc, input int stop_beats, input int budget);
        int cyc, fin_at, issued, popped;
        bit exit_now, prev_stall, prev_last;
        logic [7:0] prev_dat;
        got_dat.delete(); got_last.delete(); got_cyc.delete();
        start_cyc = -1; finish_cyc = -1; start_cnt = 0; finish_cnt = 0; done_cnt = 0;
        cen_cnt = 0; valid_cnt = 0; hold_viol = 0; ahead_viol = 0;
        busy_after = 1'b1; timed_out = 1'b1;
        fin_at = -1; issued = 0; popped = 0; exit_now = 0; prev_stall = 0;
        prev_last = 0; prev_dat = '0; cyc = 0;
        while (cyc < budget && !exit_now) begin
            i_XDS_READY = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
            if (cyc == spc) begin
                i_START = 1'b1; i_WIDTH = 10'd2; i_HEIGHT = 10'd2;
            end else begin
                i_START = 1'b0;
            end
            @(negedge i_CLK);
            if (fin_at >= 0 && cyc == fin_at + 1) begin
                busy_after = o_BUSY; timed_out = 1'b0; exit_now = 1'b1;
            end
            if (o_FRAME_START) begin start_cnt++; start_cyc = cyc; end
            if (!o_SRAM_CEN) begin issued++; cen_cnt++; end
            if (o_XDS_VALID) valid_cnt++;
            if (prev_stall && (!o_XDS_VALID || o_DEPTH !== prev_dat || o_XDS_LAST !== prev_last))
                hold_viol++;
            if (o_XDS_VALID && i_XDS_READY) begin
                popped++;
                got_dat.push_back(o_DEPTH);
                got_last.push_back(o_XDS_LAST);
                got_cyc.push_back(cyc);
            end
            if (issued - popped > 2) ahead_viol++;
            prev_stall = o_XDS_VALID && !i_XDS_READY;
            prev_dat   = o_DEPTH;
            prev_last  = o_XDS_LAST;
            if (o_FRAME_FINISH) begin finish_cnt++; finish_cyc = cyc; fin_at = cyc; end
            if (o_DONE) done_cnt++;
            if (stop_beats > 0 && got_dat.size() == stop_beats) begin
                timed_out = 1'b0; exit_now = 1'b1;
            end
            @(posedge i_CLK); #1;
            cyc++;
        end
        i_START = 1'b0;
    endtask

    task automatic test_reset();
        i_RST = 1'b1; i_START = 1'b0; i_WIDTH = '0; i_HEIGHT = '0; i_XDS_READY = 1'b1;
        repeat (2) @(posedge i_CLK);
        #1;
        @(negedge i_CLK);
        n_cmp++; if (o_BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", o_BUSY); end
        n_cmp++; if (o_DONE !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", o_DONE); end
        n_cmp++; if (o_FRAME_START !== 1'b0) begin n_bad++; $display("FAIL reset_fstart: got %b expected 0", o_FRAME_START); end
        n_cmp++; if (o_FRAME_FINISH !== 1'b0) begin n_bad++; $display("FAIL reset_ffinish: got %b expected 0", o_FRAME_FINISH); end
        n_cmp++; if (o_XDS_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", o_XDS_VALID); end
        n_cmp++; if (o_XDS_LAST !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b expected 0", o_XDS_LAST); end
        n_cmp++; if (o_DEPTH !== 8'h00) begin n_bad++; $display("FAIL reset_depth: got %h expected 00", o_DEPTH); end
        n_cmp++; if (o_SRAM_CEN !== 1'b1) begin n_bad++; $display("FAIL reset_cen: got %b expected 1", o_SRAM_CEN); end
        n_cmp++; if (o_SRAM_A !== 16'h0000) begin n_bad++; $display("FAIL reset_addr: got %h expected 0000", o_SRAM_A); end
        i_RST = 1'b0;
        @(posedge i_CLK); #1;
    endtask

    task automatic test_stream_4x3();
        logic [7:0] exp_d;
        launch(4, 3);
        collect(0, -1, -1, 100);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL s43_timeout: got %b expected 0", timed_out); end
        n_cmp++; if (got_dat.size() != 12) begin n_bad++; $display("FAIL s43_beats: got %0d expected 12", got_dat.size()); end
        for (int k = 0; k < 12 && k < got_dat.size(); k++) begin
            exp_d = 8'(k);
            n_cmp++; if (got_dat[k] !== exp_d) begin n_bad++; $display("FAIL s43_data[%0d]: got %0d expected %0d", k, got_dat[k], exp_d); end
            n_cmp++; if (got_last[k] !== (k == 11)) begin n_bad++; $display("FAIL s43_last[%0d]: got %b expected %b", k, got_last[k], (k == 11)); end
            n_cmp++; if (got_cyc[k] != k + 2) begin n_bad++; $display("FAIL s43_cycle[%0d]: got %0d expected %0d", k, got_cyc[k], k + 2); end
        end
        n_cmp++; if (start_cyc != 0) begin n_bad++; $display("FAIL s43_start_cyc: got %0d expected 0", start_cyc); end
        n_cmp++; if (finish_cyc != 14) begin n_bad++; $display("FAIL s43_finish_cyc: got %0d expected 14", finish_cyc); end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL s43_done_cnt: got %0d expected 1", done_cnt); end
        n_cmp++; if (busy_after !== 1'b0) begin n_bad++; $display("FAIL s43_busy_after: got %b expected 0", busy_after); end
        n_cmp++; if (cen_cnt != 12) begin n_bad++; $display("FAIL s43_reads: got %0d expected 12", cen_cnt); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_d;
        launch(4, 3);
        collect(1, -1, -1, 300);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL bp_timeout: got %b expected 0", timed_out); end
        n_cmp++; if (got_dat.size() != 12) begin n_bad++; $display("FAIL bp_beats: got %0d expected 12", got_dat.size()); end
        for (int k = 0; k < 12 && k < got_dat.size(); k++) begin
            exp_d = 8'(k);
            n_cmp++; if (got_dat[k] !== exp_d) begin n_bad++; $display("FAIL bp_data[%0d]: got %0d expected %0d", k, got_dat[k], exp_d); end
            n_cmp++; if (got_last[k] !== (k == 11)) begin n_bad++; $display("FAIL bp_last[%0d]: got %b expected %b", k, got_last[k], (k == 11)); end
        end
        n_cmp++; if (hold_viol != 0) begin n_bad++; $display("FAIL bp_hold: got %0d violations expected 0", hold_viol); end
        n_cmp++; if (ahead_viol != 0) begin n_bad++; $display("FAIL bp_readahead: got %0d violations expected 0", ahead_viol); end
        n_cmp++; if (cen_cnt != 12) begin n_bad++; $display("FAIL bp_reads: got %0d expected 12", cen_cnt); end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL bp_done_cnt: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_single_beat();
        sram[0] = 8'hA5;
        launch(1, 1);
        collect(0, -1, -1, 50);
        n_cmp++; if (got_dat.size() != 1) begin n_bad++; $display("FAIL one_beats: got %0d expected 1", got_dat.size()); end
        if (got_dat.size() > 0) begin
            n_cmp++; if (got_dat[0] !== 8'hA5) begin n_bad++; $display("FAIL one_data: got %h expected a5", got_dat[0]); end
            n_cmp++; if (got_last[0] !== 1'b1) begin n_bad++; $display("FAIL one_last: got %b expected 1", got_last[0]); end
            n_cmp++; if (got_cyc[0] != 2) begin n_bad++; $display("FAIL one_valid_cyc: got %0d expected 2", got_cyc[0]); end
        end
        n_cmp++; if (start_cyc != 0) begin n_bad++; $display("FAIL one_start_cyc: got %0d expected 0", start_cyc); end
        n_cmp++; if (finish_cyc != 3) begin n_bad++; $display("FAIL one_finish_cyc: got %0d expected 3", finish_cyc); end
        sram[0] = 8'h00;
    endtask

    task automatic test_empty_frame();
        launch(0, 5);
        collect(0, -1, -1, 50);
        n_cmp++; if (start_cyc != 0) begin n_bad++; $display("FAIL empty_start_cyc: got %0d expected 0", start_cyc); end
        n_cmp++; if (finish_cyc != 1) begin n_bad++; $display("FAIL empty_finish_cyc: got %0d expected 1", finish_cyc); end
        n_cmp++; if (valid_cnt != 0) begin n_bad++; $display("FAIL empty_valid: got %0d cycles expected 0", valid_cnt); end
        n_cmp++; if (cen_cnt != 0) begin n_bad++; $display("FAIL empty_reads: got %0d expected 0", cen_cnt); end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL empty_done_cnt: got %0d expected 1", done_cnt); end
        n_cmp++; if (busy_after !== 1'b0) begin n_bad++; $display("FAIL empty_busy_after: got %b expected 0", busy_after); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] exp_d;
        launch(4, 3);
        collect(0, -1, 6, 100);
        n_cmp++; if (got_dat.size() != 6) begin n_bad++; $display("FAIL mid_beats_before: got %0d expected 6", got_dat.size()); end
        i_RST = 1'b1;
        @(posedge i_CLK); #1;
        i_RST = 1'b0;
        @(negedge i_CLK);
        n_cmp++; if (o_BUSY !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b expected 0", o_BUSY); end
        n_cmp++; if (o_FRAME_FINISH !== 1'b0) begin n_bad++; $display("FAIL mid_finish: got %b expected 0", o_FRAME_FINISH); end
        n_cmp++; if (o_DONE !== 1'b0) begin n_bad++; $display("FAIL mid_done: got %b expected 0", o_DONE); end
        n_cmp++; if (o_XDS_VALID !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b expected 0", o_XDS_VALID); end
        n_cmp++; if (o_SRAM_CEN !== 1'b1) begin n_bad++; $display("FAIL mid_cen: got %b expected 1", o_SRAM_CEN); end
        n_cmp++; if (o_DEPTH !== 8'h00) begin n_bad++; $display("FAIL mid_depth: got %h expected 00", o_DEPTH); end
        @(posedge i_CLK); #1;
        launch(4, 3);
        collect(0, -1, -1, 100);
        n_cmp++; if (got_dat.size() != 12) begin n_bad++; $display("FAIL mid_rerun_beats: got %0d expected 12", got_dat.size()); end
        for (int k = 0; k < 12 && k < got_dat.size(); k++) begin
            exp_d = 8'(k);
            n_cmp++; if (got_dat[k] !== exp_d) begin n_bad++; $display("FAIL mid_rerun_data[%0d]: got %0d expected %0d", k, got_dat[k], exp_d); end
        end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL mid_rerun_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_start_ignored();
        logic [7:0] exp_d;
        launch(4, 3);
        collect(0, 5, -1, 100);
        n_cmp++; if (got_dat.size() != 12) begin n_bad++; $display("FAIL ign_beats: got %0d expected 12", got_dat.size()); end
        for (int k = 0; k < 12 && k < got_dat.size(); k++) begin
            exp_d = 8'(k);
            n_cmp++; if (got_dat[k] !== exp_d) begin n_bad++; $display("FAIL ign_data[%0d]: got %0d expected %0d", k, got_dat[k], exp_d); end
        end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL ign_done_cnt: got %0d expected 1", done_cnt); end
        n_cmp++; if (start_cnt != 1) begin n_bad++; $display("FAIL ign_start_cnt: got %0d expected 1", start_cnt); end
        n_cmp++; if (busy_after !== 1'b0) begin n_bad++; $display("FAIL ign_busy_after: got %b expected 0", busy_after); end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) sram[k] = 8'(k);
        i_SRAM_Q = '0;
        test_reset();
        test_stream_4x3();
        test_backpressure();
        test_single_beat();
        test_empty_frame();
        test_reset_midframe();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
